// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared response record and parameter limits for the instruction memory responder
package instr_mem_pkg;
  localparam int MIN_LATENCY = 1;
  localparam int MAX_LATENCY = 4;
  localparam int MAX_OUTST_LIMIT = 4;
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;
endpackage

// File: rtl/resp_delay_line.sv
// resp_delay_line: fixed-depth shift register carrying response records to the bus outputs
module resp_delay_line
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  resp_t in_i,
  output resp_t out_o
);
  resp_t stage_q [DEPTH];
  // advance one stage per cycle; only valids are cleared, payloads are masked downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i].valid <= 1'b0;
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end
  assign out_o = stage_q[DEPTH-1];
endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: req/gnt instruction-fetch responder over a word-organised RAM with fixed latency
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          RESP_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        hold_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i
);
  localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;

  if (RESP_LATENCY < MIN_LATENCY || RESP_LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("RESP_LATENCY must be within 1..4");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAX_OUTST_LIMIT) begin : g_bad_outstanding
    $error("MAX_OUTSTANDING must be within 1..4");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("BASE_ADDR must be 4-byte aligned");
  end
  if (MEM_WORDS < 1) begin : g_bad_words
    $error("MEM_WORDS must be positive");
  end

  logic [31:0] mem [MEM_WORDS];
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rd_idx, ld_idx;
  logic        rd_err, ld_ok, accept, retire;
  resp_t       req_resp, out_resp;

  assign rd_idx = (instr_addr_i - BASE_ADDR) >> 2;
  assign ld_idx = (load_addr_i - BASE_ADDR) >> 2;
  assign retire = out_resp.valid;
  assign instr_gnt_o = instr_req_i & ~hold_i & ~rst & ((cnt_q < 3'(MAX_OUTSTANDING)) | retire);

  // decode the granted address, read the word before any same-cycle load lands, and track occupancy
  always_comb begin
    rd_err   = (instr_addr_i < BASE_ADDR) || (rd_idx >= 32'(MEM_WORDS));
    ld_ok    = load_we_i && (load_addr_i >= BASE_ADDR) && (ld_idx < 32'(MEM_WORDS));
    accept   = instr_req_i & instr_gnt_o;
    req_resp = {accept, rd_err, rd_err ? 32'h0 : mem[rd_idx[AW-1:0]]};
    cnt_d    = cnt_q + 3'(accept) - 3'(retire);
  end

  // load port; the array has no reset so its contents survive rst
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_idx[AW-1:0]] <= load_wdata_i;
  end

  // count of granted requests whose response has not yet been presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 3'd0;
    else     cnt_q <= cnt_d;
  end

  resp_delay_line #(.DEPTH(RESP_LATENCY)) u_delay (
    .clk   (clk),
    .rst   (rst),
    .in_i  (req_resp),
    .out_o (out_resp)
  );

  assign instr_rvalid_o = out_resp.valid;
  assign instr_err_o    = out_resp.valid & out_resp.err;
  assign instr_rdata_o  = out_resp.valid ? out_resp.data : 32'h0;
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: two responder configurations driven together against a queue-based reference model
module tb_instr_mem_responder;
  logic clk = 1'b0, rst = 1'b1, req = 1'b1, hold = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'h0, la = 32'h0, wd = 32'h0;
  logic gnt_w [2], rv_w [2], er_w [2];
  logic [31:0] rd_w [2];
  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) dut_a (
    .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt_w[0]),
    .instr_rvalid_o(rv_w[0]), .instr_rdata_o(rd_w[0]), .instr_err_o(er_w[0]), .hold_i(hold),
    .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));

  instr_mem_responder #(.MEM_WORDS(32), .BASE_ADDR(32'h40), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt_w[1]),
    .instr_rvalid_o(rv_w[1]), .instr_rdata_o(rd_w[1]), .instr_err_o(er_w[1]), .hold_i(hold),
    .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // reference model: per configuration, a list of outstanding responses each tagged with its due cycle
  int cyc = 0;
  int qh [2] = '{0, 0};
  int qt [2] = '{0, 0};
  int qdue [2][16];
  logic qerr [2][16];
  logic [31:0] qdat [2][16];
  logic [31:0] mm [2][64];
  int lat_m [2] = '{1, 3};
  int mo_m [2] = '{2, 2};
  logic [31:0] base_m [2] = '{32'h0, 32'h40};
  int words_m [2] = '{64, 32};
  logic ev, eg, ee;
  logic [31:0] ed, off;

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        qh[i] = 0;
        qt[i] = 0;
      end
      ev = (qt[i] > qh[i]) && (qdue[i][qh[i] % 16] == cyc);
      ee = ev && qerr[i][qh[i] % 16];
      ed = ev ? qdat[i][qh[i] % 16] : 32'h0;
      eg = !rst && req && !hold && ((qt[i] - qh[i] < mo_m[i]) || ev);
      chk($sformatf("gnt%0d@%0d", i, cyc), 32'(gnt_w[i]), 32'(eg));
      chk($sformatf("rvalid%0d@%0d", i, cyc), 32'(rv_w[i]), 32'(ev));
      chk($sformatf("err%0d@%0d", i, cyc), 32'(er_w[i]), 32'(ee));
      chk($sformatf("rdata%0d@%0d", i, cyc), rd_w[i], ed);
      if (ev) qh[i]++;
      if (eg) begin
        off = addr - base_m[i];
        qdue[i][qt[i] % 16] = cyc + lat_m[i];
        qerr[i][qt[i] % 16] = (addr < base_m[i]) || ((off >> 2) >= 32'(words_m[i]));
        qdat[i][qt[i] % 16] = qerr[i][qt[i] % 16] ? 32'h0 : mm[i][off >> 2];
        qt[i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      off = la - base_m[i];
      if (we && la >= base_m[i] && (off >> 2) < 32'(words_m[i])) mm[i][off >> 2] = wd;
    end
    cyc++;
  end

  task automatic go(input logic r, input logic [31:0] a, input logic h, input logic w,
                    input logic [31:0] lad, input logic [31:0] ldat, input logic rs);
    @(posedge clk);
    #1;
    req = r; addr = a; hold = h; we = w; la = lad; wd = ldat; rst = rs;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic h);
    go(1'b1, a, h, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) go(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    go(1'b0, 32'h0, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  logic [31:0] ra, rl;

  initial begin
    @(negedge clk);
    chk("reset_gnt_a", 32'(gnt_w[0]), 32'd0);
    chk("reset_gnt_b", 32'(gnt_w[1]), 32'd0);
    chk("reset_rvalid_a", 32'(rv_w[0]), 32'd0);
    chk("reset_rdata_b", rd_w[1], 32'd0);
    for (int a = 0; a < 'h200; a += 4) ld(32'(a), $urandom);
    for (int i = 0; i < 4; i++) ld(32'(4 * i), 32'h11111111 * (i + 1));
    ld(32'h14, 32'h55555555);
    ld(32'h48, 32'hCAFE0048);
    // back-to-back fetches at single-cycle latency
    for (int i = 0; i < 4; i++) begin
      rd(32'(4 * i), 1'b0);
      chk("b2b_gnt", 32'(gnt_w[0]), 32'd1);
      if (i > 0) begin
        chk("b2b_rvalid", 32'(rv_w[0]), 32'd1);
        chk("b2b_rdata", rd_w[0], 32'h11111111 * i);
      end
    end
    idle(1);
    chk("b2b_rvalid_last", 32'(rv_w[0]), 32'd1);
    chk("b2b_rdata_last", rd_w[0], 32'h44444444);
    idle(5);
    // latency 3 with two outstanding: grant saturates in a 1,1,0 rhythm
    for (int i = 0; i < 6; i++) begin
      rd(32'h40, 1'b0);
      chk("sat_gnt", 32'(gnt_w[1]), (i % 3 != 2) ? 32'd1 : 32'd0);
      if (i == 3 || i == 4) chk("sat_rvalid", 32'(rv_w[1]), 32'd1);
    end
    idle(5);
    // unaligned address inside range, then first word past the end
    rd(32'h2, 1'b0);
    rd(32'h100, 1'b0);
    chk("unal_rvalid", 32'(rv_w[0]), 32'd1);
    chk("unal_rdata", rd_w[0], 32'h11111111);
    chk("unal_err", 32'(er_w[0]), 32'd0);
    idle(1);
    chk("oor_rvalid", 32'(rv_w[0]), 32'd1);
    chk("oor_err", 32'(er_w[0]), 32'd1);
    chk("oor_rdata", rd_w[0], 32'd0);
    idle(1);
    chk("below_base_err", 32'(er_w[1]), 32'd1);
    chk("below_base_rdata", rd_w[1], 32'd0);
    idle(4);
    // hold blocks grant while an in-flight response still drains
    rd(32'h4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rd(32'h8, 1'b1);
      chk("hold_gnt", 32'(gnt_w[0]), 32'd0);
      if (i == 0) begin
        chk("hold_rvalid", 32'(rv_w[0]), 32'd1);
        chk("hold_rdata", rd_w[0], 32'h22222222);
      end
    end
    rd(32'h8, 1'b0);
    chk("hold_release_gnt", 32'(gnt_w[0]), 32'd1);
    idle(5);
    // reset pulse discards two in-flight responses
    rd(32'h44, 1'b0);
    chk("pre_rst_gnt0", 32'(gnt_w[1]), 32'd1);
    rd(32'h48, 1'b0);
    chk("pre_rst_gnt1", 32'(gnt_w[1]), 32'd1);
    go(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("rst_gnt", 32'(gnt_w[1]), 32'd0);
    rd(32'h48, 1'b0);
    chk("post_rst_gnt", 32'(gnt_w[1]), 32'd1);
    chk("post_rst_rvalid0", 32'(rv_w[1]), 32'd0);
    idle(1);
    chk("post_rst_rvalid1", 32'(rv_w[1]), 32'd0);
    idle(1);
    chk("post_rst_rvalid2", 32'(rv_w[1]), 32'd0);
    idle(1);
    chk("post_rst_rvalid3", 32'(rv_w[1]), 32'd1);
    chk("post_rst_rdata", rd_w[1], 32'hCAFE0048);
    idle(3);
    // same-cycle load and fetch of one word returns the old contents
    go(1'b1, 32'h14, 1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 1'b0);
    chk("raw_gnt", 32'(gnt_w[0]), 32'd1);
    rd(32'h14, 1'b0);
    chk("raw_old", rd_w[0], 32'h55555555);
    idle(1);
    chk("raw_new", rd_w[0], 32'hDEADBEEF);
    idle(3);
    for (int n = 0; n < 3000; n++) begin
      ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 'h1ff));
      rl = 32'($urandom_range(0, 'h2ff));
      go($urandom_range(0, 9) < 7, ra, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
         rl, $urandom, $urandom_range(0, 299) == 0);
    end
    idle(6);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Responder end of the core's instruction-fetch bus: accepts req/gnt address beats from the fetch stage and returns in-order rvalid/rdata/err beats from a word-organised instruction memory after a fixed, parameterised latency. It sits between the fetch stage and on-chip instruction RAM. It replaces the ideal zero-wait memory model in simulation and FPGA builds. A load port fills the memory at boot or from the bench.

## Interface
- MEM_WORDS, 1024: memory depth in 32-bit words.
- BASE_ADDR, 32'h0: byte address of word 0; must be 4-byte aligned.
- RESP_LATENCY, 1: cycles from grant to rvalid; legal range 1..4.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered requests; legal range 1..4.
- clk  in  1  clock. One clock domain.
- rst  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  byte address; bits [1:0] ignored.
- instr_gnt_o  out  1  request accepted this cycle.
- instr_rvalid_o  out  1  response beat valid.
- instr_rdata_o  out  32  response word.
- instr_err_o  out  1  response is an error; qualified by rvalid.
- hold_i  in  1  forces gnt low; used for wait-state injection.
- load_we_i  in  1  memory write strobe.
- load_addr_i  in  32  byte address for the write.
- load_wdata_i  in  32  write data.

## Operation
- Outstanding counter cnt, 0..MAX_OUTSTANDING.
- retire = instr_rvalid_o.
- instr_gnt_o = instr_req_i & ~hold_i & (cnt < MAX_OUTSTANDING | retire). This is combinational from registered state only.
- accept = instr_req_i & instr_gnt_o.
- Next cnt = cnt + accept - retire.
  - accept and retire in the same cycle: cnt unchanged.
  - cnt never exceeds MAX_OUTSTANDING.
  - cnt never underflows.
- Address decode at accept:
  - off = addr - BASE_ADDR.
  - idx = off[31:2].
  - err = (addr < BASE_ADDR) | (idx >= MEM_WORDS).
- Memory read happens in the accept cycle. Data is captured with the response.
- The response record {valid, err, data} enters a RESP_LATENCY-stage delay line. The last stage drives the outputs.
- On error: rdata = 0, err = 1.
- When rvalid = 0: rdata = 0 and err = 0.
- Responses are strictly in order; none are dropped or reordered.
- Load port writes mem[(load_addr_i - BASE_ADDR) >> 2] at the clock edge.
  - Out-of-range load writes are ignored.
  - A write and a read-accept to the same word in the same cycle: the response returns the old data (read-before-write).
- hold_i affects only grant. Responses already in flight continue to drain.

## Timing
- Reset values:
  - gnt = 0 while rst is asserted.
  - rvalid = 0, rdata = 0, err = 0.
  - cnt = 0; all delay-line valids cleared.
  - Memory contents are not reset.
- Latency: a request granted in cycle k produces rvalid in cycle k + RESP_LATENCY.
- Throughput is one beat per cycle when MAX_OUTSTANDING ≥ RESP_LATENCY. Otherwise grant stalls when cnt is full and nothing is retiring.
- Reset asserted mid-operation: all in-flight responses are discarded and never appear after reset deasserts. Grant may assert in the first cycle after deassertion.
- Request held high under hold_i: the address is sampled only in the cycle gnt = 1.

## Structure
- Package instr_mem_pkg holds:
  - typedef resp_t {logic valid; logic err; logic [31:0] data;}.
  - Constants MIN_LATENCY = 1, MAX_LATENCY = 4, MAX_OUTST_LIMIT = 4.
  - Parameter range checks, done as elaboration-time assertions in the top module.
- Sub-module resp_delay_line: parameterised depth, shift register of resp_t, asynchronous clear of the valid bits.
- The memory array, decode, grant logic and counter stay in instr_mem_responder.

## Test plan
- Load mem[0..3] = 32'h11111111..32'h44444444. Run RESP_LATENCY = 1 and issue req at 0x0, 0x4, 0x8, 0xC back-to-back. Required: gnt on 4 consecutive cycles, then rvalid on 4 consecutive cycles with rdata in order.
- Run RESP_LATENCY = 3 with MAX_OUTSTANDING = 2 and hold req high. Required: gnt pattern 1,1,0,1,1,0 while cnt saturates at 2; rvalid arrives 3 cycles after each gnt.
- Request address 0x0000_0002 and then BASE_ADDR + 4*MEM_WORDS. Required: first response returns mem[0] with err = 0; second returns rvalid = 1, err = 1, rdata = 0.
- Assert hold_i for 5 cycles with req high and one response in flight. Required: gnt = 0 for those cycles and the in-flight response still appears; gnt = 1 on the cycle after hold_i drops.
- Grant two requests, then pulse rst for one cycle before their responses are due. Required: no rvalid ever appears for those requests, cnt = 0, and the next request completes normally.
- In the same cycle, load_we_i writes 0xDEADBEEF to word 5 and a request to word 5 is accepted. Required: the response returns the old value; a second read of word 5 returns 0xDEADBEEF.
